// File: rtl/spi_mem_ctrl.sv
// Sequences spi_core byte transfers into single-byte SPI memory read/write transactions.
// Define SPI_MEM_CTRL_WREN_EN to precede every write with a standalone 8'h06 write-enable transaction.
module spi_mem_ctrl #(
    parameter int              ADDR_BYTES = 3,
    parameter logic [7:0]      READ_CMD   = 8'h03,
    parameter logic [7:0]      WRITE_CMD  = 8'h02,
    parameter int              CS_SETUP   = 1,
    parameter int              CS_GAP     = 2,
    localparam int             ADDR_W     = 8 * ADDR_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              resp_valid,
    output logic [7:0]        resp_rdata,
    output logic              busy,
    output logic              spi_cs_n,
    output logic [7:0]        spi_data_tx,
    output logic              spi_txn_start,
    input  logic              spi_txn_done,
    input  logic [7:0]        spi_data_rx
);

`ifdef SPI_MEM_CTRL_WREN_EN
    localparam bit WREN_EN = 1'b1;
`else
    localparam bit WREN_EN = 1'b0;
`endif

    localparam int         N             = 2 + ADDR_BYTES;
    localparam logic [2:0] LAST_IDX      = 3'(N - 1);
    localparam logic [2:0] ADDR_LAST_IDX = 3'(ADDR_BYTES);
    localparam logic [7:0] WREN_CMD      = 8'h06;
    localparam logic [15:0] SETUP_LAST   = 16'(CS_SETUP - 1);
    localparam logic [15:0] GAP_LAST     = 16'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CSLOW,
        S_ISSUE,
        S_LAUNCH,
        S_WAIT,
        S_CSHIGH
    } state_t;

    state_t            state_reg, state_next;
    logic [2:0]        idx_reg, idx_next;
    logic [15:0]       cnt_reg, cnt_next;
    logic              write_reg, write_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [7:0]        wdata_reg, wdata_next;
    logic              wren_reg, wren_next;
    logic              cs_n_reg, cs_n_next;
    logic [7:0]        data_tx_reg, data_tx_next;
    logic              resp_valid_reg, resp_valid_next;
    logic [7:0]        rdata_reg, rdata_next;
    logic              start_c;
    logic [2:0]        last_idx;
    logic [7:0]        byte_sel;
    logic [7:0]        addr_bytes [0:7];

    // Address bytes in transmit order, MSB first; unused slots read as zero.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_addr_bytes
            if (gi < ADDR_BYTES) begin : g_used
                assign addr_bytes[gi] = addr_reg[ADDR_W-1-8*gi -: 8];
            end else begin : g_unused
                assign addr_bytes[gi] = 8'h00;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            idx_reg        <= 3'd0;
            cnt_reg        <= 16'd0;
            write_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= 8'h00;
            wren_reg       <= 1'b0;
            cs_n_reg       <= 1'b1;
            data_tx_reg    <= 8'h00;
            resp_valid_reg <= 1'b0;
            rdata_reg      <= 8'h00;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            cnt_reg        <= cnt_next;
            write_reg      <= write_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            wren_reg       <= wren_next;
            cs_n_reg       <= cs_n_next;
            data_tx_reg    <= data_tx_next;
            resp_valid_reg <= resp_valid_next;
            rdata_reg      <= rdata_next;
        end
    end

    assign last_idx = wren_reg ? 3'd0 : LAST_IDX;

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        cnt_next        = cnt_reg;
        write_next      = write_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        wren_next       = wren_reg;
        cs_n_next       = cs_n_reg;
        resp_valid_next = 1'b0;
        rdata_next      = rdata_reg;
        start_c         = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    write_next = req_write;
                    addr_next  = req_addr;
                    wdata_next = req_wdata;
                    wren_next  = WREN_EN && req_write;
                    idx_next   = 3'd0;
                    cnt_next   = 16'd0;
                    cs_n_next  = 1'b0;
                    state_next = S_CSLOW;
                end
            end
            S_CSLOW: begin
                if (cnt_reg == SETUP_LAST) begin
                    cnt_next   = 16'd0;
                    state_next = S_ISSUE;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_ISSUE: begin
                if (spi_txn_done) begin
                    start_c    = 1'b1;
                    state_next = S_LAUNCH;
                end
            end
            // The core only drops its idle flag one cycle after start, so done is not trusted here.
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT: begin
                if (spi_txn_done) begin
                    if (idx_reg == last_idx) begin
                        cs_n_next  = 1'b1;
                        cnt_next   = 16'd0;
                        state_next = S_CSHIGH;
                        if (!wren_reg) begin
                            resp_valid_next = 1'b1;
                            if (!write_reg) rdata_next = spi_data_rx;
                        end
                    end else begin
                        idx_next   = idx_reg + 3'd1;
                        state_next = S_ISSUE;
                    end
                end
            end
            S_CSHIGH: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next = 16'd0;
                    if (wren_reg) begin
                        // Write-enable phase done: reopen CS for the real write.
                        wren_next  = 1'b0;
                        idx_next   = 3'd0;
                        cs_n_next  = 1'b0;
                        state_next = S_CSLOW;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Next byte is loaded on entry to ISSUE so it is stable from start through done.
    always_comb begin
        byte_sel = 8'h00;
        if (wren_next) begin
            byte_sel = WREN_CMD;
        end else if (idx_next == 3'd0) begin
            byte_sel = write_reg ? WRITE_CMD : READ_CMD;
        end else if (idx_next <= ADDR_LAST_IDX) begin
            byte_sel = addr_bytes[idx_next - 3'd1];
        end else begin
            byte_sel = write_reg ? wdata_reg : 8'h00;
        end
        data_tx_next = data_tx_reg;
        if (state_next == S_ISSUE && state_reg != S_ISSUE) data_tx_next = byte_sel;
    end

    assign req_ready     = (state_reg == S_IDLE);
    assign busy          = ~req_ready;
    assign resp_valid    = resp_valid_reg;
    assign resp_rdata    = rdata_reg;
    assign spi_cs_n      = cs_n_reg;
    assign spi_data_tx   = data_tx_reg;
    assign spi_txn_start = start_c;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl with a cycle-accurate behavioural spi_core model.
// Latency is counted inclusively from the accept cycle to the resp_valid cycle.
module tb_spi_mem_ctrl;
    localparam int ADDR_BYTES = 3;
    localparam int CS_SETUP   = 1;
    localparam int CS_GAP     = 2;
    localparam int BYTE_CYC   = 3;
    localparam int N          = 2 + ADDR_BYTES;
`ifdef SPI_MEM_CTRL_WREN_EN
    localparam bit WREN = 1'b1;
`else
    localparam bit WREN = 1'b0;
`endif
    localparam int BASE_LAT   = 1 + CS_SETUP + N * (2 + BYTE_CYC) + 1;
    localparam int WREN_EXTRA = CS_SETUP + (2 + BYTE_CYC) + CS_GAP;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [23:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        busy;
    logic        spi_cs_n;
    logic [7:0]  spi_data_tx;
    logic        spi_txn_start;
    logic        spi_txn_done;
    logic [7:0]  spi_data_rx;

    int checks;
    int failures;

    spi_mem_ctrl #(
        .ADDR_BYTES(ADDR_BYTES),
        .READ_CMD  (8'h03),
        .WRITE_CMD (8'h02),
        .CS_SETUP  (CS_SETUP),
        .CS_GAP    (CS_GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .busy         (busy),
        .spi_cs_n     (spi_cs_n),
        .spi_data_tx  (spi_data_tx),
        .spi_txn_start(spi_txn_start),
        .spi_txn_done (spi_txn_done),
        .spi_data_rx  (spi_data_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // spi_core model: busy for BYTE_CYC cycles starting the cycle after start.
    logic       core_busy;
    int         core_cnt;
    int         core_bytes;
    logic       done_block;
    logic [7:0] rd_val;

    assign spi_txn_done = !core_busy && !done_block;

    always @(posedge clk) begin
        if (rst) begin
            core_busy   <= 1'b0;
            core_cnt    <= 0;
            core_bytes  <= 0;
            spi_data_rx <= 8'h00;
        end else begin
            if (spi_txn_start && !core_busy) begin
                core_busy   <= 1'b1;
                core_cnt    <= BYTE_CYC - 1;
                spi_data_rx <= (core_bytes == N - 1) ? rd_val : 8'hFF;
                core_bytes  <= core_bytes + 1;
            end else if (core_busy) begin
                if (core_cnt == 0) core_busy <= 1'b0;
                else core_cnt <= core_cnt - 1;
            end
            if (spi_cs_n) core_bytes <= 0;
        end
    end

    // Bus monitor
    logic [7:0] tx_q[$];
    int cyc = 0, acc_cnt = 0, acc_cyc = 0, resp_cnt = 0, resp_cyc = 0;
    int cs_fall = 0, last_gap = 0, high_run = 0, bad_start = 0, ready_bad = 0;
    logic cs_n_prev = 1'b1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (req_valid && req_ready) begin
                acc_cnt <= acc_cnt + 1;
                acc_cyc <= cyc;
            end
            if (resp_valid) begin
                resp_cnt <= resp_cnt + 1;
                resp_cyc <= cyc;
            end
            if (spi_txn_start) tx_q.push_back(spi_data_tx);
            if (spi_txn_start && spi_cs_n) bad_start <= bad_start + 1;
            if (req_ready && !spi_cs_n) ready_bad <= ready_bad + 1;
            if (cs_n_prev && !spi_cs_n) begin
                cs_fall  <= cs_fall + 1;
                last_gap <= high_run;
            end
            high_run <= spi_cs_n ? high_run + 1 : 0;
        end
        cs_n_prev <= spi_cs_n;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_req(input logic wr, input logic [23:0] addr, input logic [7:0] wd,
                             input logic [7:0] rv);
        int  a0;
        bit  seen;
        @(negedge clk);
        a0        = acc_cnt;
        rd_val    = rv;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        seen      = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (acc_cnt != a0) seen = 1'b1;
        end
        req_valid = 1'b0;
        chk("accept_seen", seen, 1'b1);
    endtask

    task automatic wait_resp(input int base);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (resp_cnt != base) seen = 1'b1;
        end
        chk("resp_seen", seen, 1'b1);
    endtask

    typedef struct {
        logic        wr;
        logic [23:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rv;
        logic [39:0] exp_tx;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input int i);
        logic [7:0]  exp_q[$];
        logic [39:0] tx;
        int f0, r0, lat, exp_lat;
        tx = vecs[i].exp_tx;
        exp_q.delete();
        if (WREN && vecs[i].wr) exp_q.push_back(8'h06);
        for (int j = 0; j < N; j++) exp_q.push_back(tx[39-8*j -: 8]);
        exp_lat = BASE_LAT + ((WREN && vecs[i].wr) ? WREN_EXTRA : 0);
        tx_q.delete();
        f0 = cs_fall;
        r0 = resp_cnt;
        start_req(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].rv);
        wait_resp(r0);
        repeat (CS_GAP + 2) @(negedge clk);
        lat = resp_cyc - acc_cyc + 1;
        chk($sformatf("v%0d_tx_count", i), tx_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size(); j++)
            if (j < tx_q.size()) chk($sformatf("v%0d_tx_byte%0d", i, j), tx_q[j], exp_q[j]);
        chk($sformatf("v%0d_resp_pulses", i), resp_cnt - r0, 1);
        chk($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].exp_rdata);
        chk($sformatf("v%0d_latency", i), lat, exp_lat);
        chk($sformatf("v%0d_cs_falls", i), cs_fall - f0, (WREN && vecs[i].wr) ? 2 : 1);
        chk($sformatf("v%0d_cs_gap", i), last_gap >= CS_GAP, 1'b1);
        $display("txn %0d %s addr=%06h wdata=%02h rdata=%02h latency=%0d bytes=%0d",
                 i, vecs[i].wr ? "write" : "read ", vecs[i].addr, vecs[i].wd, resp_rdata,
                 lat, tx_q.size());
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, a0, lat;
        bit seen;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 24'h0;
        req_wdata  = 8'h00;
        done_block = 1'b0;
        rd_val     = 8'h00;

        vecs[0] = '{1'b0, 24'h012345, 8'h00, 8'hA5, 40'h03_01_23_45_00, 8'hA5};
        vecs[1] = '{1'b1, 24'h00FFEE, 8'h5A, 8'h11, 40'h02_00_FF_EE_5A, 8'hA5};
        vecs[2] = '{1'b0, 24'hFFFFFF, 8'h00, 8'h3C, 40'h03_FF_FF_FF_00, 8'h3C};
        vecs[3] = '{1'b1, 24'h000000, 8'hFF, 8'h22, 40'h02_00_00_00_FF, 8'h3C};
        vecs[4] = '{1'b0, 24'h800001, 8'h00, 8'h00, 40'h03_80_00_01_00, 8'h00};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 8'h00);
        chk("rst_cs_n", spi_cs_n, 1'b1);
        chk("rst_data_tx", spi_data_tx, 8'h00);
        chk("rst_txn_start", spi_txn_start, 1'b0);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Back-to-back reads with req_valid held high.
        tx_q.delete();
        a0 = acc_cnt;
        r0 = resp_cnt;
        @(negedge clk);
        rd_val    = 8'h77;
        req_write = 1'b0;
        req_addr  = 24'h000010;
        req_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (acc_cnt == a0 + 2) seen = 1'b1;
        end
        req_valid = 1'b0;
        chk("b2b_second_accept", seen, 1'b1);
        chk("b2b_resp_before_2nd", resp_cnt - r0, 1);
        chk("b2b_accept_gap", acc_cyc - resp_cyc, CS_GAP);
        chk("b2b_cs_high_run", last_gap >= CS_GAP, 1'b1);
        wait_resp(r0 + 1);
        repeat (CS_GAP + 2) @(negedge clk);
        chk("b2b_resp_total", resp_cnt - r0, 2);
        chk("b2b_tx_count", tx_q.size(), 2 * N);
        chk("b2b_rdata", resp_rdata, 8'h77);
        $display("txn b2b two reads addr=000010 rdata=%02h bytes=%0d", resp_rdata, tx_q.size());

        // Core reports not-idle for 5 extra cycles while the controller sits in ISSUE.
        tx_q.delete();
        r0 = resp_cnt;
        done_block = 1'b1;
        start_req(1'b0, 24'h0000AA, 8'h00, 8'h99);
        repeat (CS_SETUP + 5) @(negedge clk);
        chk("slow_no_start_count", tx_q.size(), 0);
        chk("slow_start_low", spi_txn_start, 1'b0);
        chk("slow_cs_low", spi_cs_n, 1'b0);
        done_block = 1'b0;
        #1;
        chk("slow_start_on_done", spi_txn_start, 1'b1);
        wait_resp(r0);
        repeat (CS_GAP + 2) @(negedge clk);
        lat = resp_cyc - acc_cyc + 1;
        chk("slow_latency", lat, BASE_LAT + 5);
        chk("slow_rdata", resp_rdata, 8'h99);
        chk("slow_tx_count", tx_q.size(), N);
        if (tx_q.size() == N) chk("slow_tx_addr_lsb", tx_q[3], 8'hAA);
        $display("txn slow read addr=0000AA rdata=%02h latency=%0d", resp_rdata, lat);

        // Reset during the third byte aborts the transaction.
        tx_q.delete();
        r0 = resp_cnt;
        start_req(1'b0, 24'hABCDEF, 8'h00, 8'h44);
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (tx_q.size() == 3) seen = 1'b1;
        end
        chk("abort_third_byte", seen, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cs_n", spi_cs_n, 1'b1);
        chk("abort_req_ready", req_ready, 1'b1);
        chk("abort_txn_start", spi_txn_start, 1'b0);
        chk("abort_resp_valid", resp_valid, 1'b0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_resp", resp_cnt - r0, 0);
        chk("abort_rdata_cleared", resp_rdata, 8'h00);
        chk("abort_idle_cs_n", spi_cs_n, 1'b1);
        $display("txn abort read addr=ABCDEF bytes_sent=%0d", tx_q.size());

        chk("start_with_cs_high", bad_start, 0);
        chk("ready_with_cs_low", ready_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
